// File: rtl/gray_binary_seq.sv
// Handshaked Gray-to-binary converter: resolves one binary bit per clock, MSB first,
// and holds the finished word on a valid/ready output until the consumer takes it.
module gray_binary_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] binary_out,
    output logic             busy
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] g_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (in_valid)    state_nx = CONV;
            CONV:    if (idx == '0)   state_nx = DONE;
            DONE:    if (out_ready)   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // One XOR per cycle: the bit below the last resolved one.
    always_comb begin
        idx_p1      = idx + 1'b1;
        acc_nx      = acc;
        acc_nx[idx] = acc[idx_p1] ^ g_reg[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_reg      <= '0;
            acc        <= '0;
            idx        <= '0;
            binary_out <= '0;
        end else if (state == IDLE && in_valid) begin
            g_reg <= gray_in;
            acc   <= {gray_in[WIDTH-1], {(WIDTH-1){1'b0}}};
            idx   <= IDX_START;
        end else if (state == CONV) begin
            acc <= acc_nx;
            idx <= idx - 1'b1;
            // Publish only the complete word so partial results never reach the port.
            if (idx == '0) begin
                binary_out <= acc_nx;
            end
        end
    end

endmodule

// File: tb/tb_gray_binary_seq.sv
// Directed bench for gray_binary_seq at WIDTH=4 and WIDTH=8.
module tb_gray_binary_seq;

    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0] gray4, binary_out4;
    logic       in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0] gray8, binary_out8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gray_binary_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .gray_in(gray4), .out_valid(out_valid4), .out_ready(out_ready4),
        .binary_out(binary_out4), .busy(busy4)
    );

    gray_binary_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .gray_in(gray8), .out_valid(out_valid8), .out_ready(out_ready8),
        .binary_out(binary_out8), .busy(busy8)
    );

    function automatic logic [3:0] ref_g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (binary_out4 !== 4'b0000) begin errors++; $display("FAIL reset_bin4 got %b want 0000", binary_out4); end
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_ovalid4 got %b want 0", out_valid4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got %b want 0", busy4); end
        checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL reset_iready4 got %b want 0", in_ready4); end
        checks++; if (in_ready8 !== 1'b0 || binary_out8 !== 8'h00) begin errors++; $display("FAIL reset_u8 got ir=%b bin=%h want 0/00", in_ready8, binary_out8); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL release_iready4 got %b want 1", in_ready4); end
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL release_iready8 got %b want 1", in_ready8); end
        tick();
    endtask

    // Accept g, check hold of previous result, 3-edge latency, value and release to IDLE.
    task automatic do_conv4(input logic [3:0] g, input logic [3:0] exp, input string name);
        int         lat;
        logic [3:0] prev;
        prev = binary_out4;
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL %s_pre_ready got %b want 1", name, in_ready4); end
        gray4 = g;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        gray4 = ~g;
        checks++; if (busy4 !== 1'b1 || binary_out4 !== prev) begin errors++; $display("FAIL %s_conv busy=%b bin=%b want 1/%b", name, busy4, binary_out4, prev); end
        lat = 1;
        while (out_valid4 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        lat--;
        checks++; if (lat !== 3) begin errors++; $display("FAIL %s_latency got %0d want 3", name, lat); end
        checks++; if (binary_out4 !== exp) begin errors++; $display("FAIL %s_value got %b want %b", name, binary_out4, exp); end
        tick();
        checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin errors++; $display("FAIL %s_release ov=%b ir=%b want 0/1", name, out_valid4, in_ready4); end
    endtask

    task automatic test_directed();
        out_ready4 = 1'b1;
        do_conv4(4'b0000, 4'b0000, "dir0000");
        do_conv4(4'b0011, 4'b0010, "dir0011");
        do_conv4(4'b1000, 4'b1111, "dir1000");
        do_conv4(4'b1101, 4'b1001, "dir1101");
    endtask

    task automatic test_exhaustive();
        int last_acc;
        int n;
        out_ready4 = 1'b1;
        in_valid4 = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 16; i++) begin
            gray4 = 4'(i);
            n = 0;
            while (in_ready4 !== 1'b1 && n < 20) begin tick(); n++; end
            if (n >= 20) begin checks++; errors++; $display("FAIL exh_ready_timeout i=%0d got %b want 1", i, in_ready4); end
            tick();
            if (i > 0) begin
                checks++; if (cyc - last_acc !== 5) begin errors++; $display("FAIL exh_spacing i=%0d got %0d want 5", i, cyc - last_acc); end
            end
            last_acc = cyc;
            gray4 = 4'(i + 7);
            n = 0;
            while (out_valid4 !== 1'b1 && n < 20) begin tick(); n++; end
            checks++; if (binary_out4 !== ref_g2b(4'(i)) || out_valid4 !== 1'b1) begin
                errors++; $display("FAIL exh_value g=%0d got %b ov=%b want %b", i, binary_out4, out_valid4, ref_g2b(4'(i)));
            end
            checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL exh_done_ready g=%0d got %b want 0", i, in_ready4); end
        end
        in_valid4 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int   n;
        logic stable;
        out_ready4 = 1'b0;
        gray4 = 4'b0110;
        in_valid4 = 1'b1;
        tick();
        gray4 = 4'b1010;
        n = 0;
        while (out_valid4 !== 1'b1 && n < 20) begin tick(); n++; end
        stable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (out_valid4 !== 1'b1 || binary_out4 !== 4'b0100 || in_ready4 !== 1'b0) stable = 1'b0;
            tick();
        end
        checks++; if (stable !== 1'b1 || binary_out4 !== 4'b0100) begin errors++; $display("FAIL bp_hold got ov=%b bin=%b ir=%b want 1/0100/0", out_valid4, binary_out4, in_ready4); end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        tick();
        checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin errors++; $display("FAIL bp_release ov=%b ir=%b busy=%b want 0/1/0", out_valid4, in_ready4, busy4); end
        checks++; if (binary_out4 !== 4'b0100) begin errors++; $display("FAIL bp_idle_hold got %b want 0100", binary_out4); end
    endtask

    task automatic test_reset_mid();
        logic rose;
        out_ready4 = 1'b1;
        gray4 = 4'b1111;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (busy4 !== 1'b0 || out_valid4 !== 1'b0 || binary_out4 !== 4'b0000) begin
            errors++; $display("FAIL rstmid_state busy=%b ov=%b bin=%b want 0/0/0000", busy4, out_valid4, binary_out4);
        end
        rose = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid4 !== 1'b0) rose = 1'b1;
            tick();
        end
        checks++; if (rose !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid got %b want 0", rose); end
        do_conv4(4'b0001, 4'b0001, "post_rst0001");
    endtask

    task automatic do_conv8(input logic [7:0] g, input logic [7:0] exp, input string name);
        int lat;
        out_ready8 = 1'b1;
        gray8 = g;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        gray8 = 8'h00;
        lat = 1;
        while (out_valid8 !== 1'b1 && lat < 30) begin tick(); lat++; end
        lat--;
        checks++; if (lat !== 7) begin errors++; $display("FAIL %s_latency got %0d want 7", name, lat); end
        checks++; if (binary_out8 !== exp) begin errors++; $display("FAIL %s_value got %b want %b", name, binary_out8, exp); end
        tick();
        checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin errors++; $display("FAIL %s_release ov=%b ir=%b want 0/1", name, out_valid8, in_ready8); end
    endtask

    task automatic test_width8();
        do_conv8(8'b10000000, 8'b11111111, "w8_80");
        do_conv8(8'b01010101, 8'b01100110, "w8_55");
    endtask

    initial begin
        rst = 1'b1;
        in_valid4 = 1'b0; out_ready4 = 1'b1; gray4 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; gray8 = '0;
        tick();
        test_reset();
        test_directed();
        test_exhaustive();
        test_backpressure();
        test_reset_mid();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
